// File: rtl/el2_pkg.sv
// Shared fetch-path definitions: fetch-buffer depth and entry layout used by
// both fetch control and the fetch buffer.
package el2_pkg;

  localparam int FB_DEPTH = 4;
  localparam int FB_PTR_W = 2;
  localparam int FB_CNT_W = 3;

  typedef struct packed {
    logic [31:0] data;
    logic [31:2] pc;
    logic [1:0]  mask;   // bit i set = halfword i still unconsumed
    logic        fault;
  } fb_entry_t;

  // Index of the lowest valid halfword; only 2'b10 starts at halfword 1.
  function automatic logic lo_hw(input logic [1:0] mask);
    return (mask == 2'b10);
  endfunction

endpackage

// File: rtl/el2_ifu_fb_align.sv
// Combinational aligner: builds one 16/32-bit instruction from the head entry
// and, when a 32-bit instruction straddles, the next entry.
module el2_ifu_fb_align
  import el2_pkg::*;
(
  input  fb_entry_t   head,
  input  fb_entry_t   next,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:1] pc,
  output logic        pc4,
  output logic        icaf,
  output logic [1:0]  head_clr,
  output logic [1:0]  next_clr
);

  logic        head_vld, next_vld;
  logic        head_idx, next_idx;
  logic [15:0] head_hw, next_hw;
  logic        is32, in_head;

  assign head_vld = |head.mask;
  assign next_vld = |next.mask;
  assign head_idx = lo_hw(head.mask);
  assign next_idx = lo_hw(next.mask);
  assign head_hw  = head_idx ? head.data[31:16] : head.data[15:0];
  assign next_hw  = next_idx ? next.data[31:16] : next.data[15:0];
  assign is32     = (head_hw[1:0] == 2'b11);
  assign in_head  = ~head_idx & head.mask[1];

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    valid    = 1'b0;
    instr    = '0;
    pc       = '0;
    pc4      = 1'b0;
    icaf     = 1'b0;
    head_clr = 2'b00;
    next_clr = 2'b00;
    if (head_vld) begin
      pc  = {head.pc, head_idx};
      pc4 = is32;
      if (head.fault) begin
        // A faulted packet is dropped whole, plus the straddling tail if present.
        valid    = 1'b1;
        icaf     = 1'b1;
        head_clr = head.mask;
        if (is32 && !in_head && next_vld) next_clr[next_idx] = 1'b1;
      end else if (!is32) begin
        valid              = 1'b1;
        instr              = {16'h0000, head_hw};
        head_clr[head_idx] = 1'b1;
      end else if (in_head) begin
        valid    = 1'b1;
        instr    = head.data;
        head_clr = 2'b11;
      end else if (next_vld) begin
        valid              = 1'b1;
        head_clr[head_idx] = 1'b1;
        next_clr[next_idx] = 1'b1;
        if (next.fault) icaf  = 1'b1;
        else            instr = {next_hw, head_hw};
      end
    end
  end

endmodule

// File: rtl/el2_ifu_fetch_buf.sv
// Four-entry circular fetch buffer feeding decode one aligned instruction per
// cycle and reporting retired entries back to fetch control.
module el2_ifu_fetch_buf
  import el2_pkg::*;
(
  input  logic                clk,
  input  logic                rst_l,
  input  logic                ifc_fetch_req_f,
  input  logic                ic_hit_f,
  input  logic [30:0]         ifc_fetch_addr_f,
  input  logic [31:0]         ic_data_f,
  input  logic                ic_access_fault_f,
  input  logic                exu_flush_final,
  input  logic                dec_i0_decode_d,
  output logic                ifu_i0_valid,
  output logic [31:0]         ifu_i0_instr,
  output logic [30:0]         ifu_i0_pc,
  output logic                ifu_i0_pc4,
  output logic                ifu_i0_icaf,
  output logic                ifu_fb_consume1,
  output logic                ifu_fb_consume2,
  output logic [FB_CNT_W-1:0] ifu_fb_count
);

  logic [31:0]         fb_data  [FB_DEPTH];
  logic [31:2]         fb_pc    [FB_DEPTH];
  logic                fb_fault [FB_DEPTH];
  logic [1:0]          fb_mask  [FB_DEPTH];
  logic [FB_PTR_W-1:0] wr_ptr, rd_ptr, nx_ptr;
  logic [FB_CNT_W-1:0] fb_count_q;

  fb_entry_t   head, next;
  logic        al_valid, al_pc4, al_icaf;
  logic [31:0] al_instr;
  logic [31:1] al_pc;
  logic [1:0]  head_clr, next_clr, head_left, next_left, wr_mask;
  logic        retire_go, head_ret, next_ret, wr_req, wr_ok, fb_full;
  logic [1:0]  n_retired;

  assign nx_ptr = rd_ptr + 1'b1;
  assign head   = '{data: fb_data[rd_ptr], pc: fb_pc[rd_ptr], mask: fb_mask[rd_ptr], fault: fb_fault[rd_ptr]};
  assign next   = '{data: fb_data[nx_ptr], pc: fb_pc[nx_ptr], mask: fb_mask[nx_ptr], fault: fb_fault[nx_ptr]};

  el2_ifu_fb_align u_align (
    .head     (head),
    .next     (next),
    .valid    (al_valid),
    .instr    (al_instr),
    .pc       (al_pc),
    .pc4      (al_pc4),
    .icaf     (al_icaf),
    .head_clr (head_clr),
    .next_clr (next_clr)
  );

  assign retire_go = al_valid & dec_i0_decode_d & ~exu_flush_final;
  assign head_left = head.mask & ~head_clr;
  assign next_left = next.mask & ~next_clr;
  assign head_ret  = retire_go & (head_left == 2'b00);
  assign next_ret  = retire_go & (|next_clr) & (next_left == 2'b00);
  assign n_retired = {1'b0, head_ret} + {1'b0, next_ret};

  // A full buffer still takes a write when the head slot frees this cycle.
  assign wr_req  = ifc_fetch_req_f & ic_hit_f & ~exu_flush_final;
  assign fb_full = (fb_count_q == FB_CNT_W'(FB_DEPTH));
  assign wr_ok   = wr_req & (~fb_full | head_ret);
  assign wr_mask = ifc_fetch_addr_f[0] ? 2'b10 : 2'b11;

  assign ifu_i0_valid    = al_valid & ~exu_flush_final;
  assign ifu_i0_instr    = al_instr;
  assign ifu_i0_pc       = al_pc;
  assign ifu_i0_pc4      = ifu_i0_valid & al_pc4;
  assign ifu_i0_icaf     = ifu_i0_valid & al_icaf;
  assign ifu_fb_consume1 = head_ret & ~next_ret;
  assign ifu_fb_consume2 = next_ret;
  assign ifu_fb_count    = fb_count_q;

  // NOTE: state uses non-blocking assignments; the write to wr_ptr comes last so it wins over a same-slot clear.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < FB_DEPTH; i++) fb_mask[i] <= 2'b00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fb_count_q <= '0;
    end else if (exu_flush_final) begin
      for (int i = 0; i < FB_DEPTH; i++) fb_mask[i] <= 2'b00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fb_count_q <= '0;
    end else begin
      if (retire_go) begin
        fb_mask[rd_ptr] <= head_left;
        fb_mask[nx_ptr] <= next_left;
      end
      if (wr_ok) fb_mask[wr_ptr] <= wr_mask;
      wr_ptr     <= wr_ptr + FB_PTR_W'(wr_ok);
      rd_ptr     <= rd_ptr + FB_PTR_W'(n_retired);
      fb_count_q <= fb_count_q + FB_CNT_W'(wr_ok) - FB_CNT_W'(n_retired);
    end
  end

  // NOTE: payload storage is deliberately not reset; a zero mask makes stale contents invisible.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      fb_data[wr_ptr]  <= ic_data_f;
      fb_pc[wr_ptr]    <= ifc_fetch_addr_f[30:1];
      fb_fault[wr_ptr] <= ic_access_fault_f;
    end
  end

  wr_overflow_a: assert property (@(posedge clk) disable iff (!rst_l)
    !(wr_req && fb_full && !head_ret));

endmodule

// File: tb/tb_el2_ifu_fetch_buf.sv
// Directed bench for the fetch buffer: each task drives one scenario and
// compares the presented instruction, consume pulses and count.
module tb_el2_ifu_fetch_buf;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        ifc_fetch_req_f, ic_hit_f, ic_access_fault_f;
  logic        exu_flush_final, dec_i0_decode_d;
  logic [30:0] ifc_fetch_addr_f;
  logic [31:0] ic_data_f;
  logic        ifu_i0_valid, ifu_i0_pc4, ifu_i0_icaf;
  logic [31:0] ifu_i0_instr;
  logic [30:0] ifu_i0_pc;
  logic        ifu_fb_consume1, ifu_fb_consume2;
  logic [2:0]  ifu_fb_count;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [70:0] e;
  logic [5:0]  ec;

  el2_ifu_fetch_buf dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .ifc_fetch_req_f   (ifc_fetch_req_f),
    .ic_hit_f          (ic_hit_f),
    .ifc_fetch_addr_f  (ifc_fetch_addr_f),
    .ic_data_f         (ic_data_f),
    .ic_access_fault_f (ic_access_fault_f),
    .exu_flush_final   (exu_flush_final),
    .dec_i0_decode_d   (dec_i0_decode_d),
    .ifu_i0_valid      (ifu_i0_valid),
    .ifu_i0_instr      (ifu_i0_instr),
    .ifu_i0_pc         (ifu_i0_pc),
    .ifu_i0_pc4        (ifu_i0_pc4),
    .ifu_i0_icaf       (ifu_i0_icaf),
    .ifu_fb_consume1   (ifu_fb_consume1),
    .ifu_fb_consume2   (ifu_fb_consume2),
    .ifu_fb_count      (ifu_fb_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [70:0] obs();
    return {ifu_i0_valid, ifu_i0_instr, ifu_i0_pc, ifu_i0_pc4, ifu_i0_icaf,
            ifu_fb_consume1, ifu_fb_consume2, ifu_fb_count};
  endfunction

  function automatic logic [5:0] obs_ctl();
    return {ifu_i0_valid, ifu_fb_consume1, ifu_fb_consume2, ifu_fb_count};
  endfunction

  // Expected full vector from a byte address.
  function automatic logic [70:0] exp_v(input logic v, input logic [31:0] ins,
                                        input logic [31:0] addr, input logic p4,
                                        input logic ic, input logic c1,
                                        input logic c2, input logic [2:0] cnt);
    return {v, ins, addr[31:1], p4, ic, c1, c2, cnt};
  endfunction

  task automatic drive(input logic req, input logic [31:0] addr, input logic [31:0] data,
                       input logic flt, input logic dec, input logic fl);
    ifc_fetch_req_f   = req;
    ic_hit_f          = req;
    ifc_fetch_addr_f  = addr[31:1];
    ic_data_f         = data;
    ic_access_fault_f = flt;
    dec_i0_decode_d   = dec;
    exu_flush_final   = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic dec);
    drive(1'b0, 32'h0, 32'h0, 1'b0, dec, 1'b0);
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    idle(1'b0);
    tick();
    tick();
    e = '0;
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL reset_state: got %h want %h", obs(), e); end
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_aligned();
    drive(1'b1, 32'h100, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    ec = 6'b0;
    vec_cnt++;
    if (obs_ctl() !== ec) begin err_cnt++; $display("FAIL aligned_empty: got %h want %h", obs_ctl(), ec); end
    tick();
    drive(1'b1, 32'h104, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    e = exp_v(1, 32'h0000_0013, 32'h100, 1, 0, 1, 0, 3'd1);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL aligned_0: got %h want %h", obs(), e); end
    tick();
    idle(1'b1);
    e = exp_v(1, 32'h0000_0013, 32'h104, 1, 0, 1, 0, 3'd1);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL aligned_1: got %h want %h", obs(), e); end
    tick();
    ec = 6'b0;
    vec_cnt++;
    if (obs_ctl() !== ec) begin err_cnt++; $display("FAIL aligned_drain: got %h want %h", obs_ctl(), ec); end
  endtask

  task automatic test_mixed();
    drive(1'b1, 32'h200, 32'h0001_4501, 1'b0, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    e = exp_v(1, 32'h0000_4501, 32'h200, 0, 0, 0, 0, 3'd1);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL mixed_hw0: got %h want %h", obs(), e); end
    tick();
    e = exp_v(1, 32'h0000_0001, 32'h202, 0, 0, 1, 0, 3'd1);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL mixed_hw1: got %h want %h", obs(), e); end
    tick();
    ec = 6'b0;
    vec_cnt++;
    if (obs_ctl() !== ec) begin err_cnt++; $display("FAIL mixed_drain: got %h want %h", obs_ctl(), ec); end
  endtask

  task automatic test_spanning();
    drive(1'b1, 32'h300, 32'h0513_0001, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h306, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    e = exp_v(1, 32'h0000_0001, 32'h300, 0, 0, 0, 0, 3'd1);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL span_hold: got %h want %h", obs(), e); end
    tick();
    idle(1'b1);
    e = exp_v(1, 32'h0000_0001, 32'h300, 0, 0, 0, 0, 3'd2);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL span_hw0: got %h want %h", obs(), e); end
    tick();
    e = exp_v(1, 32'h0000_0513, 32'h302, 1, 0, 0, 1, 3'd2);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL span_consume2: got %h want %h", obs(), e); end
    tick();
    ec = 6'b0;
    vec_cnt++;
    if (obs_ctl() !== ec) begin err_cnt++; $display("FAIL span_drain: got %h want %h", obs_ctl(), ec); end
  endtask

  task automatic test_full_retire();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(i * 4), 32'h0000_0013, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle(1'b0);
    e = exp_v(1, 32'h0000_0013, 32'h500, 1, 0, 0, 0, 3'd4);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL full_hold: got %h want %h", obs(), e); end
    drive(1'b1, 32'h510, 32'h0010_0093, 1'b0, 1'b1, 1'b0);
    e = exp_v(1, 32'h0000_0013, 32'h500, 1, 0, 1, 0, 3'd4);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL full_wr_retire: got %h want %h", obs(), e); end
    tick();
    idle(1'b0);
    e = exp_v(1, 32'h0000_0013, 32'h504, 1, 0, 0, 0, 3'd4);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL full_after: got %h want %h", obs(), e); end
    idle(1'b1);
    tick();
    tick();
    tick();
    e = exp_v(1, 32'h0010_0093, 32'h510, 1, 0, 1, 0, 3'd1);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL full_last: got %h want %h", obs(), e); end
    tick();
    ec = 6'b0;
    vec_cnt++;
    if (obs_ctl() !== ec) begin err_cnt++; $display("FAIL full_drain: got %h want %h", obs_ctl(), ec); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h600 + 32'(i * 4), 32'h0000_0013, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle(1'b0);
    e = exp_v(1, 32'h0000_0013, 32'h600, 1, 0, 0, 0, 3'd3);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL flush_pre: got %h want %h", obs(), e); end
    drive(1'b1, 32'h60C, 32'h0000_0013, 1'b0, 1'b1, 1'b1);
    ec = {1'b0, 1'b0, 1'b0, 3'd3};
    vec_cnt++;
    if (obs_ctl() !== ec) begin err_cnt++; $display("FAIL flush_same: got %h want %h", obs_ctl(), ec); end
    tick();
    idle(1'b0);
    ec = 6'b0;
    vec_cnt++;
    if (obs_ctl() !== ec) begin err_cnt++; $display("FAIL flush_next: got %h want %h", obs_ctl(), ec); end
  endtask

  task automatic test_fault();
    drive(1'b1, 32'h400, 32'h1234_4501, 1'b1, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    e = exp_v(1, 32'h0, 32'h400, 0, 1, 0, 0, 3'd1);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL fault_hold: got %h want %h", obs(), e); end
    idle(1'b1);
    e = exp_v(1, 32'h0, 32'h400, 0, 1, 1, 0, 3'd1);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL fault_consume: got %h want %h", obs(), e); end
    tick();
    ec = 6'b0;
    vec_cnt++;
    if (obs_ctl() !== ec) begin err_cnt++; $display("FAIL fault_drain: got %h want %h", obs_ctl(), ec); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h800, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h804, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    tick();
    idle(1'b1);
    rst_l = 1'b0;
    #1;
    e = '0;
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL reset_mid: got %h want %h", obs(), e); end
    tick();
    rst_l = 1'b1;
    drive(1'b1, 32'h900, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    tick();
    idle(1'b1);
    e = exp_v(1, 32'h0000_0013, 32'h900, 1, 0, 1, 0, 3'd1);
    vec_cnt++;
    if (obs() !== e) begin err_cnt++; $display("FAIL reset_restart: got %h want %h", obs(), e); end
    tick();
    idle(1'b0);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_mixed();
    test_spanning();
    test_full_retire();
    test_flush();
    test_fault();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/el2_ifu_fetch_buf.md
Name: el2_ifu_fetch_buf

Overview:
- Receiver end of the fetch pipe. Captures each fetch packet that hits in the F stage into a 4-entry circular fetch buffer.
- Aligns the captured halfwords into 16- and 32-bit instructions and presents one instruction per cycle to decode.
- Reports consumed entries back to fetch control on ifu_fb_consume1/ifu_fb_consume2. Fetch control uses these for its fetch-buffer mass-balance model, so the depth and consume semantics here must match that model exactly.

Parameters:
- FB_DEPTH, 4, number of fetch-packet entries; fixed to match the 4-bit fetch control write model.
- FB_PTR_W, 2, log2(FB_DEPTH).

Ports:
- clk  input  1  core clock (active clock).
- rst_l  input  1  reset; one clock, reset is asynchronous and active-low.
- ifc_fetch_req_f  input  1  fetch request valid, F stage.
- ic_hit_f  input  1  icache/ICCM hit, F stage.
- ifc_fetch_addr_f  input  31  fetch address [31:1], F stage.
- ic_data_f  input  32  fetch packet data; halfword0 = [15:0], halfword1 = [31:16].
- ic_access_fault_f  input  1  access fault on this fetch.
- exu_flush_final  input  1  flush; kills buffer contents.
- dec_i0_decode_d  input  1  decode accepts the presented instruction this cycle.
- ifu_i0_valid  output  1  instruction presented.
- ifu_i0_instr  output  32  instruction; upper 16 bits zero for compressed.
- ifu_i0_pc  output  31  instruction PC [31:1].
- ifu_i0_pc4  output  1  1 = 32-bit instruction.
- ifu_i0_icaf  output  1  instruction carries an access fault.
- ifu_fb_consume1  output  1  exactly one entry retired this cycle.
- ifu_fb_consume2  output  1  two entries retired this cycle.
- ifu_fb_count  output  3  occupied entries (0..4).

Behaviour:
- Write condition: wr_en = ifc_fetch_req_f & ic_hit_f & ~exu_flush_final.
- Each entry stores data[31:0], pc[31:2], a 2-bit halfword valid mask, and fault.
  - Mask = 2'b11 when addr[1]=0; 2'b10 when addr[1]=1 (odd target, single halfword).
- Entries written at wr_ptr; wr_ptr and count increment on write. Pointers wrap modulo 4.
- Write when count==4 with no same-cycle retire is a protocol violation:
  - write is dropped;
  - simulation assertion fires.
- Head halfword = lowest set mask bit of the head entry. Instruction length: ifu_i0_pc4 = (head_hw[1:0]==2'b11).
- ifu_i0_valid conditions:
  - 16-bit: head entry has a valid halfword.
  - 32-bit: two consecutive valid halfwords are available, either both in the head entry or head hw1 plus the next entry's lowest valid halfword.
  - Any entry holding a needed halfword has fault=1: valid is asserted when the head entry is present, with icaf=1, instr=0, pc = head halfword PC.
- ifu_i0_pc = {head.pc[31:2], head halfword index}.
- Retire on ifu_i0_valid & dec_i0_decode_d. Consumed halfwords are cleared from their masks.
  - An entry whose mask becomes 0 is retired: rd_ptr advances and count decrements.
  - 1 entry retired -> consume1=1. 2 entries retired -> consume2=1 (32-bit spanning head hw1 plus a single-halfword next entry, or icaf across two entries). Never both.
  - consume1/consume2 are combinational, same cycle as the decode accept. Fetch control samples them same cycle.
- Simultaneous write and retire: count += 1 - retired. A write into a slot freed in the same cycle is legal at count==4.
- Flush (exu_flush_final=1):
  - Same cycle: ifu_i0_valid=0, consume1=consume2=0, any write suppressed.
  - Next cycle: all masks are 0, pointers = 0, count = 0.
- Reset: all masks, pointers, and count = 0. ifu_i0_valid, consume1, consume2, icaf, and pc4 = 0. instr and pc are don't-care but driven 0. Reset mid-operation discards all entries with no consume pulses.
- Storage: data is held in enable-gated flops, not reset; only the masks and control state are reset.

Decomposition:
- Add the fetch-buffer entry struct (data, pc, mask, fault) and the FB_DEPTH constant to el2_pkg, so fetch control and the buffer share one depth.
- One natural sub-module: el2_ifu_fb_align. It is combinational: given head and next entries, it produces valid, instr, pc, pc4, icaf, and the halfword-consume mask.

Test Plan:
- Aligned 32-bit stream: writes at 0x100, 0x104 with 0x00000013 each, decode always -> two 32-bit instrs at pc 0x100/0x104, consume1 each cycle, count returns 0.
- Mixed compressed: packet 0x0001_4501 @0x200 -> instr 0x4501 pc 0x200 (pc4=0, no consume), then 0x0001 pc 0x202 with consume1=1.
- Spanning + consume2: packet @0x300 hw1 = 0x0513 (32-bit low), then odd write @0x306 (mask 10) hw1 = 0x0000 -> instr 0x00000513 pc 0x302, consume2=1, count drops by 2.
- Full with simultaneous retire: fill 4 entries, assert write and decode of a full head-entry instruction same cycle -> write accepted, count stays 4, no assertion.
- Flush mid-stream: count=3, exu_flush_final with write and decode asserted -> valid=0, consume1/2=0 that cycle, count=0 next cycle.
- Access fault: write @0x400 with ic_access_fault_f=1 -> valid, icaf=1, instr=0, pc 0x400, consume1 on decode.
